mtimer_clint: RTL
=================

Name: mtimer_clint

Overview:
Memory-mapped machine-timer peripheral for the RudolV SoC bus. It holds one free-running 64-bit mtime and NUM_CMP 64-bit mtimecmp registers, one per hart or interrupt channel. Each channel drives a registered irq_timer line. The block replaces ad-hoc timer logic in benches and SoC tops, adding a prescaler, multiple channels and a bus-visible hit flag for the read-data mux.

Parameters:
BASE_ADDR, 32'h4400_0000, region base; decode compares addr[31:16] with BASE_ADDR[31:16]
NUM_CMP, 2, number of mtimecmp/irq channels (1..8)
PRESCALE, 1, clock cycles per mtime increment (1..65535); 1 means increment every cycle

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
mem_valid  in  1  bus request strobe
mem_write  in  1  1 = write, 0 = read
mem_wmask  in  4  byte enables
mem_wdata  in  32  write data
mem_addr  in  32  byte address
mem_rdata  out  32  read data, registered
mem_sel  out  1  registered; 1 = previous-cycle request hit this region
irq_timer  out  NUM_CMP  per-channel timer interrupt, registered
mtime_o  out  64  current mtime, for CSR time/timeh

Behaviour:
- Reset (async, rstn=0): mtime=0; every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; prescale counter=0; irq_timer=0; mem_rdata=0; mem_sel=0.
- Register map, offsets from BASE_ADDR, word-aligned:
  - 0x4000+8*i: mtimecmp[i][31:0]
  - 0x4004+8*i: mtimecmp[i][63:32]
  - 0xBFF8: mtime[31:0]
  - 0xBFFC: mtime[63:32]
- hit = mem_valid & region match. mem_sel <= hit every cycle.
- Reads:
  - Condition: hit & !mem_write.
  - mem_rdata is updated at the next clk edge, giving 1-cycle latency.
  - Unmapped in-region offsets, and channels with i >= NUM_CMP, return 32'hFFFF_FFFF.
  - mem_rdata holds its value until the next read hit.
- Writes:
  - Condition: hit & mem_write & (mem_wmask==4'b1111).
  - Partial-mask writes are ignored with no side effect.
  - A write to one half leaves the other half unchanged.
- mtime increment:
  - The prescale counter counts 0..PRESCALE-1. tick=1 when counter==PRESCALE-1, and the counter then wraps to 0.
  - On tick, mtime <= mtime+1, with full 64-bit carry. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Simultaneous software write to an mtime half and tick: the write wins for the whole 64-bit register. No increment occurs that cycle and no carry propagates into the other half. The prescale counter is not disturbed.
- irq_timer[i] <= (mtime >= mtimecmp[i]) as an unsigned 64-bit compare on register values.
  - Effective latency is 1 cycle after the register update.
  - irq stays high until mtimecmp[i] is raised above mtime or mtime wraps.
- mtime_o is the mtime register value.
- No internal state machine beyond the prescaler. Reset mid-operation clears everything immediately, regardless of a pending read.

Optional Feature:
MTIMER_ATOMIC_READ_EN
- Defined:
  - A read of the mtime lo half (0xBFF8) latches mtime[63:32] into a shadow register in the same edge.
  - A read of 0xBFFC returns the shadow, not the live value. This gives a tear-free lo-then-hi 64-bit read.
  - The shadow resets to 0.
- Undefined:
  - 0xBFFC returns live mtime[63:32].
  - No shadow register exists.

Decomposition:
- Package mtimer_pkg:
  - offset localparams MTIMECMP_OFS=16'h4000, MTIME_LO_OFS=16'hBFF8, MTIME_HI_OFS=16'hBFFC
  - CMP_STRIDE=8
  - RDATA_UNMAPPED=32'hFFFF_FFFF
- Sub-module mtimer_prescaler:
  - parameter PRESCALE; ports clk, rstn, tick out.
  - Counter width is $clog2(PRESCALE) (min 1).
  - PRESCALE=1 yields a constant tick=1 out of reset.

Test Plan:
- Reset, then 10 cycles with PRESCALE=1 -> mtime_o=10, read 0xBFF8 returns 10 one cycle later, mem_sel=1, irq_timer=0.
- Write mtimecmp[1]={0,20}: hi first, then lo -> irq_timer[1] rises on the cycle after mtime reaches 20; irq_timer[0] stays 0. Then write mtimecmp[1] hi=1 -> irq_timer[1] drops 1 cycle later.
- Write mtime lo=32'hFFFF_FFFF, hi=0 -> next tick gives mtime={1,0} (carry). Write 64'hFFFF_FFFF_FFFF_FFFF -> wraps to 0.
- Write with wmask=4'b0011 to 0x4000 -> mtimecmp[0] unchanged (reads 32'hFFFF_FFFF). Read 0x4010 with NUM_CMP=2 -> 32'hFFFF_FFFF. Address 0x4500_0000 -> mem_sel=0.
- PRESCALE=4, write to mtime lo on a tick cycle -> mtime equals written value (no +1), and the next increment occurs 4 cycles later.
- MTIMER_ATOMIC_READ_EN: mtime={0,FFFF_FFFE}, read lo, wait 5 cycles, read hi -> hi=0 (shadow). Without the macro -> hi=1.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared register-map constants for the mtimer_clint machine-timer block.
package mtimer_pkg;

  localparam logic [15:0] MTIMECMP_OFS   = 16'h4000;
  localparam logic [15:0] MTIME_LO_OFS   = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFS   = 16'hBFFC;
  localparam int          CMP_STRIDE     = 8;
  localparam logic [31:0] RDATA_UNMAPPED = 32'hFFFF_FFFF;

  // Offset of the lo (hi=0) or hi (hi=1) word of compare channel idx.
  function automatic logic [15:0] cmp_ofs(input int idx, input logic hi);
    return MTIMECMP_OFS + 16'(CMP_STRIDE * idx) + (hi ? 16'd4 : 16'd0);
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides clk down to a one-cycle mtime increment strobe every PRESCALE cycles.
module mtimer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With PRESCALE=1 the counter is pinned at 0 and tick is permanently high.
  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mtimer_clint.sv
// Memory-mapped 64-bit mtime with NUM_CMP mtimecmp channels and registered irqs.
// Build option MTIMER_ATOMIC_READ_EN: lo-half read latches a hi-half shadow.
module mtimer_clint
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4400_0000,
  parameter int          NUM_CMP   = 2,
  parameter int          PRESCALE  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               mem_valid,
  input  logic               mem_write,
  input  logic [3:0]         mem_wmask,
  input  logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_addr,
  output logic [31:0]        mem_rdata,
  output logic               mem_sel,
  output logic [NUM_CMP-1:0] irq_timer,
  output logic [63:0]        mtime_o
);

  logic        hit, rd_en, wr_en, tick;
  logic [15:0] ofs;
  logic [31:0] mtime_hi_rd;

  logic [63:0]               mtime_q, mtime_d;
  logic [NUM_CMP-1:0][63:0]  cmp_q, cmp_d;
  logic [NUM_CMP-1:0]        irq_q, irq_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      sel_q;

  assign hit   = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]);
  assign ofs   = mem_addr[15:0];
  assign rd_en = hit && !mem_write;
  assign wr_en = hit && mem_write && (mem_wmask == 4'b1111);

  mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

`ifdef MTIMER_ATOMIC_READ_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              shadow_q <= '0;
    else if (rd_en && ofs == MTIME_LO_OFS)  shadow_q <= mtime_q[63:32];
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  // A software write to either half replaces the whole increment for that edge.
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en && ofs == MTIME_LO_OFS) mtime_d = {mtime_q[63:32], mem_wdata};
    if (wr_en && ofs == MTIME_HI_OFS) mtime_d = {mem_wdata, mtime_q[31:0]};
  end

  always_comb begin
    cmp_d = cmp_q;
    irq_d = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (wr_en && ofs == cmp_ofs(i, 1'b0)) cmp_d[i][31:0]  = mem_wdata;
      if (wr_en && ofs == cmp_ofs(i, 1'b1)) cmp_d[i][63:32] = mem_wdata;
      irq_d[i] = (mtime_q >= cmp_q[i]);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = RDATA_UNMAPPED;
      if (ofs == MTIME_LO_OFS) rdata_d = mtime_q[31:0];
      if (ofs == MTIME_HI_OFS) rdata_d = mtime_hi_rd;
      for (int i = 0; i < NUM_CMP; i++) begin
        if (ofs == cmp_ofs(i, 1'b0)) rdata_d = cmp_q[i][31:0];
        if (ofs == cmp_ofs(i, 1'b1)) rdata_d = cmp_q[i][63:32];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      irq_q   <= '0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      sel_q   <= hit;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_sel   = sel_q;
  assign irq_timer = irq_q;
  assign mtime_o   = mtime_q;

endmodule
